// File: rtl/dense2_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dense2_seq_ctrl
//
// Sequencer for the second dense layer. One start pulse runs one inference:
//   1. PRIME   : present address 0 to the hidden buffer (1-cycle read latency).
//   2. STREAM  : N_IN cycles; each cycle forwards the activation returned for
//                the previous address to the MAC datapath with frame strobes.
//   3. WAIT    : keep the datapath enabled until mac_valid, or abort after
//                TIMEOUT cycles with err=1.
//   4. ARGMAX  : N_OUT cycles, one signed compare per cycle over the captured
//                class sums; the lowest index wins ties.
//   5. DONE    : one-cycle done pulse, then back to IDLE.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle inference request, ignored unless IDLE
//   buf_addr            hidden-buffer read address (registered)
//   buf_rdata           signed activation for the previous cycle's buf_addr
//   mac_ena             datapath enable (STREAM and WAIT)
//   mac_frame_start     marks activation 0 on mac_data
//   mac_frame_end       marks activation N_IN-1 on mac_data
//   mac_data            activation to datapath (buf_rdata while streaming)
//   mac_valid           datapath result valid, only observed in WAIT
//   mac_sum             N_OUT signed 16-bit biased class sums, class i at [16i+:16]
//   busy                high from the cycle after start is accepted until done
//   done                one-cycle completion pulse
//   err                 qualifies done; 1 = timeout abort
//   class_idx           argmax class index
//   class_score         winning signed class sum
//
// All control outputs are registered: each *_d value is derived from the next
// state, so the output is valid in the same cycle the FSM is in that state.
// -----------------------------------------------------------------------------
module dense2_seq_ctrl #(
  parameter int N_IN    = 120,
  parameter int ADDR_W  = 7,
  parameter int N_OUT   = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_W-1:0]     buf_addr,
  input  logic [15:0]           buf_rdata,
  output logic                  mac_ena,
  output logic                  mac_frame_start,
  output logic                  mac_frame_end,
  output logic [15:0]           mac_data,
  input  logic                  mac_valid,
  input  logic [16*N_OUT-1:0]   mac_sum,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            class_idx,
  output logic [15:0]           class_score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_WAIT,
    S_ARGMAX,
    S_DONE
  } state_e;

  localparam int              WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(N_IN - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);
  localparam logic [3:0]        LAST_ARG  = 4'(N_OUT - 1);

  // FSM and bookkeeping
  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   k_q,          k_d;        // STREAM element index
  logic [WAIT_W-1:0]   wait_q,       wait_d;     // cycles spent in WAIT
  logic [3:0]          arg_q,        arg_d;      // ARGMAX compare index
  logic [16*N_OUT-1:0] result_q,     result_d;   // captured sums, shifted down
  logic [15:0]         best_q,       best_d;
  logic [3:0]          best_idx_q,   best_idx_d;

  // Registered outputs
  logic [ADDR_W-1:0]   buf_addr_q,    buf_addr_d;
  logic                mac_ena_q,     mac_ena_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_end_q,   frame_end_d;
  logic                busy_q,        busy_d;
  logic                done_q,        done_d;
  logic                err_q,         err_d;
  logic [3:0]          class_idx_q,   class_idx_d;
  logic [15:0]         class_score_q, class_score_d;

  // ARGMAX compare of the current candidate against the running best
  logic [15:0]         cand;
  logic                take;
  logic [15:0]         win_score;
  logic [3:0]          win_idx;

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    wait_d        = wait_q;
    arg_d         = arg_q;
    result_d      = result_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    err_d         = 1'b0;
    buf_addr_d    = '0;

    // The captured sums are shifted down one class per ARGMAX cycle, so the
    // candidate is always the low word. Compare index 0 loads unconditionally;
    // later indices replace only on a strictly greater signed value.
    cand      = result_q[15:0];
    take      = (arg_q == 4'd0) || ($signed(cand) > $signed(best_q));
    win_score = take ? cand  : best_q;
    win_idx   = take ? arg_q : best_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        state_d = S_STREAM;
        k_d     = '0;
      end

      S_STREAM: begin
        if (k_q == LAST_K) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (mac_valid) begin
          state_d  = S_ARGMAX;
          result_d = mac_sum;
          arg_d    = 4'd0;
        end else if (wait_q == LAST_WAIT) begin
          // Timeout abort: class outputs are left untouched.
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_ARGMAX: begin
        best_d     = win_score;
        best_idx_d = win_idx;
        result_d   = result_q >> 16;
        if (arg_q == LAST_ARG) begin
          state_d       = S_DONE;
          class_idx_d   = win_idx;
          class_score_d = win_score;
        end else begin
          arg_d = arg_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read address one element ahead of the element being streamed, held at
    // the last element so the buffer is never read past its end. It holds in
    // WAIT and is parked at 0 everywhere else (so PRIME presents address 0).
    if (state_d == S_STREAM) begin
      buf_addr_d = (k_d == LAST_K) ? LAST_K : k_d + 1'b1;
    end else if (state_d == S_WAIT) begin
      buf_addr_d = buf_addr_q;
    end

    mac_ena_d     = (state_d == S_STREAM) || (state_d == S_WAIT);
    frame_start_d = (state_d == S_STREAM) && (state_q == S_PRIME);
    frame_end_d   = (state_d == S_STREAM) && (k_d == LAST_K);
    busy_d        = (state_d == S_PRIME) || (state_d == S_STREAM) ||
                    (state_d == S_WAIT)  || (state_d == S_ARGMAX);
    done_d        = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its *_d value from before the edge regardless of statement order.
  // NOTE: the captured-sum and best-score registers are reset as well; a
  // reset mid-inference must leave no stale result that could reach
  // class_idx/class_score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      wait_q        <= '0;
      arg_q         <= '0;
      result_q      <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      buf_addr_q    <= '0;
      mac_ena_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wait_q        <= wait_d;
      arg_q         <= arg_d;
      result_q      <= result_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      buf_addr_q    <= buf_addr_d;
      mac_ena_q     <= mac_ena_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
    end
  end

  assign buf_addr        = buf_addr_q;
  assign mac_ena         = mac_ena_q;
  assign mac_frame_start = frame_start_q;
  assign mac_frame_end   = frame_end_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign class_idx       = class_idx_q;
  assign class_score     = class_score_q;

  // Buffer data passes straight through while streaming; outside STREAM the
  // datapath sees zero so nothing stale leaks out (and reset drives it to 0).
  assign mac_data = (state_q == S_STREAM) ? buf_rdata : 16'h0000;

endmodule

// File: tb/tb_dense2_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dense2_seq_ctrl
//
// Self-checking bench for dense2_seq_ctrl with N_IN=4, N_OUT=10, TIMEOUT=64.
// A table of hand-derived vectors covers the documented corner cases; random
// runs are checked against a reference argmax computed over the class sums.
// Cycle numbering: the cycle in which start is sampled is cycle 0.
// -----------------------------------------------------------------------------
module tb_dense2_seq_ctrl;

  localparam int N_IN    = 4;
  localparam int ADDR_W  = 7;
  localparam int N_OUT   = 10;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   buf_addr;
  logic [15:0]         buf_rdata = 16'h0000;
  logic                mac_ena;
  logic                mac_frame_start;
  logic                mac_frame_end;
  logic [15:0]         mac_data;
  logic                mac_valid = 1'b0;
  logic [16*N_OUT-1:0] mac_sum = '0;
  logic                busy;
  logic                done;
  logic                err;
  logic [3:0]          class_idx;
  logic [15:0]         class_score;

  logic [15:0] mem [N_IN];

  int n_checks = 0;
  int n_errors = 0;

  // Last class result the DUT should be holding
  logic [3:0]  ref_idx   = 4'd0;
  logic [15:0] ref_score = 16'h0000;

  dense2_seq_ctrl #(
    .N_IN   (N_IN),
    .ADDR_W (ADDR_W),
    .N_OUT  (N_OUT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .buf_addr       (buf_addr),
    .buf_rdata      (buf_rdata),
    .mac_ena        (mac_ena),
    .mac_frame_start(mac_frame_start),
    .mac_frame_end  (mac_frame_end),
    .mac_data       (mac_data),
    .mac_valid      (mac_valid),
    .mac_sum        (mac_sum),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .class_idx      (class_idx),
    .class_score    (class_score)
  );

  always #5 clk = ~clk;

  // Hidden buffer with one cycle of read latency
  always @(posedge clk) begin
    buf_rdata <= (int'(buf_addr) < N_IN) ? mem[buf_addr] : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " buf_addr"},    32'(buf_addr),        32'd0);
    check({tag, " mac_ena"},     32'(mac_ena),         32'd0);
    check({tag, " frame_start"}, 32'(mac_frame_start), 32'd0);
    check({tag, " frame_end"},   32'(mac_frame_end),   32'd0);
    check({tag, " mac_data"},    32'(mac_data),        32'd0);
    check({tag, " busy"},        32'(busy),            32'd0);
    check({tag, " done"},        32'(done),            32'd0);
    check({tag, " err"},         32'(err),             32'd0);
    check({tag, " class_idx"},   32'(class_idx),       32'd0);
    check({tag, " class_score"}, 32'(class_score),     32'd0);
  endtask

  // Reference argmax: largest signed value, first occurrence wins.
  function automatic void ref_argmax(input logic [16*N_OUT-1:0] s,
                                     output logic [3:0] idx, output logic [15:0] score);
    int best;
    int v;
    best = $signed(s[15:0]);
    idx  = 4'd0;
    for (int i = 1; i < N_OUT; i++) begin
      v = $signed(s[16*i +: 16]);
      if (v > best) begin
        best = v;
        idx  = 4'(i);
      end
    end
    score = best[15:0];
  endfunction

  // One inference. Entered in cycle 0 (just after an edge); returns in the
  // IDLE cycle directly after DONE, so a following call starts right there.
  // d < 0 means mac_valid never comes. stray_c puts an extra start (and a
  // stray mac_valid) in that cycle; stray_done adds a start in the DONE cycle.
  task automatic run_inf(input string tag, input logic [16*N_OUT-1:0] sums, input int d,
                         input int stray_c, input bit stray_done,
                         input bit e_err, input logic [3:0] e_idx, input logic [15:0] e_score);
    int  done_c;
    int  wait_last;
    bit  tmo;
    tmo       = (d < 0);
    done_c    = tmo ? N_IN + 2 + TIMEOUT : N_IN + d + N_OUT + 3;
    wait_last = tmo ? N_IN + 1 + TIMEOUT : N_IN + 2 + d;
    mac_sum   = sums;
    start     = 1'b1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      start     = (c == stray_c) || (stray_done && (c == done_c));
      mac_valid = (!tmo && (c == N_IN + 2 + d)) || (c == stray_c);

      check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c < done_c));
      check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == done_c));
      check($sformatf("%s c%0d err", tag, c),  32'(err),  32'((c == done_c) && e_err));
      check($sformatf("%s c%0d mac_ena", tag, c), 32'(mac_ena), 32'((c >= 2) && (c <= wait_last)));
      check($sformatf("%s c%0d frame_start", tag, c), 32'(mac_frame_start), 32'(c == 2));
      check($sformatf("%s c%0d frame_end", tag, c),   32'(mac_frame_end),   32'(c == N_IN + 1));
      if (c == 1) begin
        check($sformatf("%s c%0d buf_addr", tag, c), 32'(buf_addr), 32'd0);
      end
      if ((c >= 2) && (c <= N_IN + 1)) begin
        check($sformatf("%s c%0d buf_addr", tag, c), 32'(buf_addr), 32'((c - 1 < N_IN - 1) ? c - 1 : N_IN - 1));
        check($sformatf("%s c%0d mac_data", tag, c), 32'(mac_data), 32'(mem[c - 2]));
      end
      if (c == N_IN + 2) begin
        check($sformatf("%s c%0d buf_addr", tag, c), 32'(buf_addr), 32'(N_IN - 1));
      end
      check($sformatf("%s c%0d class_idx", tag, c),   32'(class_idx),   32'((c >= done_c) ? e_idx : ref_idx));
      check($sformatf("%s c%0d class_score", tag, c), 32'(class_score), 32'((c >= done_c) ? e_score : ref_score));
    end
    mac_valid = 1'b0;
    start     = 1'b0;
    ref_idx   = e_idx;
    ref_score = e_score;
  endtask

  typedef struct {
    logic [16*N_OUT-1:0] sums;
    int                  d;
    int                  stray_c;
    bit                  stray_done;
    bit                  e_err;
    logic [3:0]          e_idx;
    logic [15:0]         e_score;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [16*N_OUT-1:0] rs;
    logic [3:0]          ri;
    logic [15:0]         rsc;
    int                  rd;

    // Sums are written class 9 first, class 0 last (class i at [16i+:16]).
    vecs[0] = '{ {16'hFD41, 16'hFF89, 16'hFD84, 16'h00C4, 16'h01CC,
                  16'h0446, 16'h0116, 16'hFD11, 16'h0012, 16'h00A8},
                 3, -1, 1'b0, 1'b0, 4'd4, 16'h0446 };
    vecs[1] = '{ {16'hFF09, 16'hFF08, 16'hFFFF, 16'hFF06, 16'hFF05,
                  16'hFF04, 16'hFF03, 16'hFF02, 16'hFF01, 16'hFF00},
                 0, 3, 1'b1, 1'b0, 4'd7, 16'hFFFF };
    vecs[2] = '{ {16'hFFFF, 16'h7FFD, 16'h1234, 16'h8001, 16'h7FFF,
                  16'h7FFE, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFE},
                 5, -1, 1'b0, 1'b0, 4'd2, 16'h7FFF };
    // Timeout: class outputs keep the previous result
    vecs[3] = '{ {10{16'h1111}}, -1, -1, 1'b0, 1'b1, 4'd2, 16'h7FFF };
    // All equal: index 0 wins; mac_valid on the last legal WAIT cycle
    vecs[4] = '{ {10{16'h8000}}, TIMEOUT - 1, -1, 1'b0, 1'b0, 4'd0, 16'h8000 };
    vecs[5] = '{ {16'h0001, {9{16'h0000}}}, 1, -1, 1'b0, 1'b0, 4'd9, 16'h0001 };

    mem[0] = 16'h0100;
    mem[1] = 16'hFF00;
    mem[2] = 16'h0080;
    mem[3] = 16'h0001;

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("idle");

    // Table vectors, back to back: each start lands in the IDLE cycle right
    // after the previous DONE.
    for (int v = 0; v < 6; v++) begin
      run_inf($sformatf("vec%0d", v), vecs[v].sums, vecs[v].d, vecs[v].stray_c,
              vecs[v].stray_done, vecs[v].e_err, vecs[v].e_idx, vecs[v].e_score);
    end

    // Nothing may be queued: stay idle
    repeat (4) begin
      @(posedge clk);
      #1;
      check("idle busy", 32'(busy), 32'd0);
      check("idle done", 32'(done), 32'd0);
    end

    // Reset asserted in WAIT: outputs drop at once, no done follows
    start = 1'b1;
    for (int c = 1; c <= N_IN + 4; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pre_reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("held_reset");
    end
    rst_n     = 1'b1;
    ref_idx   = 4'd0;
    ref_score = 16'h0000;
    @(posedge clk);
    #1;
    check_zero("after_reset");
    run_inf("post_reset", vecs[0].sums, vecs[0].d, -1, 1'b0, 1'b0, 4'd4, 16'h0446);

    // Randomized runs against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N_IN; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < N_OUT; i++) begin
        case ($urandom_range(0, 3))
          0:       rs[16*i +: 16] = 16'h7FFF;
          1:       rs[16*i +: 16] = 16'h8000;
          2:       rs[16*i +: 16] = (i > 0) ? rs[16*(i-1) +: 16] : 16'($urandom);
          default: rs[16*i +: 16] = 16'($urandom);
        endcase
      end
      rd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      if (rd < 0) begin
        ri  = ref_idx;
        rsc = ref_score;
      end else begin
        ref_argmax(rs, ri, rsc);
      end
      run_inf($sformatf("rnd%0d", r), rs, rd, -1, 1'b0, rd < 0, ri, rsc);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
